// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, response/bit timing, checksum check.
// Presents humidity/temperature bytes with valid / error pulses.
//
// state     | meaning
// IDLE      | bus released, waiting for start
// START_LOW | host drives the bus low for START_LOW_US
// RELEASE   | bus released, waiting for sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low preamble of a data bit
// BIT_HIGH  | high phase of a data bit; width decides 0/1
// CHECK     | verify checksum, publish frame or flag error
// TIMEOUT   | a sensor phase ran too long, flag error
module dht11_reader #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int START_LOW_US = 18000,
    parameter int BIT1_THR_US  = 40,
    parameter int TIMEOUT_US   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    inout  wire        dht11_data,
    output logic       busy,
    output logic       valid,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       err_checksum,
    output logic       err_timeout
);

    localparam int DIV   = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LOAD = (DIV > 1) ? PRE_W'(1) : '0;
    localparam logic [15:0] US_LOAD   = (DIV > 1) ? 16'd0 : 16'd1;
    localparam logic [15:0] START_LIM = 16'(START_LOW_US);
    localparam logic [15:0] THR_LIM   = 16'(BIT1_THR_US);
    localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT_US);

    typedef enum logic [3:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, CHECK, TIMEOUT
    } state_t;

    state_t state, next_state;

    logic             data_s1, data_s2, data_d;
    logic             rise, fall;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      us_cnt;
    logic [39:0]      shift;
    logic [5:0]       bit_cnt;
    logic [7:0]       sum_w;
    logic             sum_ok;
    logic             timed_out;

    assign dht11_data = (state == START_LOW) ? 1'b0 : 1'bz;

    assign rise      = data_s2 & ~data_d;
    assign fall      = ~data_s2 & data_d;
    assign timed_out = (us_cnt > TMO_LIM);
    assign sum_w     = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];
    assign sum_ok    = (sum_w == shift[7:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            data_d  <= 1'b1;
        end else begin
            data_s1 <= dht11_data;
            data_s2 <= data_s1;
            data_d  <= data_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = START_LOW;
            START_LOW: if (us_cnt == START_LIM) next_state = RELEASE;
            RELEASE:   if (fall) next_state = RESP_LOW;
                       else if (timed_out) next_state = TIMEOUT;
            RESP_LOW:  if (rise) next_state = RESP_HIGH;
                       else if (timed_out) next_state = TIMEOUT;
            RESP_HIGH: if (fall) next_state = BIT_LOW;
                       else if (timed_out) next_state = TIMEOUT;
            BIT_LOW:   if (rise) next_state = BIT_HIGH;
                       else if (timed_out) next_state = TIMEOUT;
            BIT_HIGH:  if (fall) next_state = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                       else if (timed_out) next_state = TIMEOUT;
            CHECK:     next_state = IDLE;
            TIMEOUT:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The entry cycle counts as elapsed time, so us_cnt equals the whole
    // measured width when the closing edge is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (next_state != state) begin
            pre_cnt <= PRE_LOAD;
            us_cnt  <= US_LOAD;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && next_state == START_LOW) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state == BIT_HIGH && fall) begin
            shift   <= {shift[38:0], (us_cnt > THR_LIM)};
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            valid        <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            hum_int      <= '0;
            hum_dec      <= '0;
            temp_int     <= '0;
            temp_dec     <= '0;
        end else begin
            busy         <= (next_state != IDLE);
            valid        <= (state == CHECK) && sum_ok;
            err_checksum <= (state == CHECK) && !sum_ok;
            err_timeout  <= (state == TIMEOUT);
            if (state == CHECK && sum_ok) begin
                hum_int  <= shift[39:32];
                hum_dec  <= shift[31:24];
                temp_int <= shift[23:16];
                temp_dec <= shift[15:8];
            end
        end
    end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a DHT11 sensor model drives frames on the bus and a
// frame-level model predicts each outcome (good frame, checksum error, timeout).
module tb_dht11_reader;

    localparam int CLK_HZ       = 2_000_000;
    localparam int DIV          = CLK_HZ / 1_000_000;
    localparam int START_LOW_US = 100;
    localparam int BIT1_THR_US  = 40;
    localparam int TIMEOUT_US   = 255;

    localparam int K_OK  = 1;
    localparam int K_CK  = 2;
    localparam int K_TMO = 3;

    typedef struct {
        int          kind;
        logic [31:0] bytes;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sensor_low;
    wire        dht11_data;
    logic       busy, valid, err_checksum, err_timeout;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

    int          errors = 0;
    int          checks = 0;
    int          hi_w[40];
    ev_t         ev_q[$];
    logic [31:0] model_bytes = '0;
    ev_t         cur_ev;
    int          got_kind;

    pullup (dht11_data);
    assign dht11_data = sensor_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_reader #(
        .CLK_HZ      (CLK_HZ),
        .START_LOW_US(START_LOW_US),
        .BIT1_THR_US (BIT1_THR_US),
        .TIMEOUT_US  (TIMEOUT_US)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dht11_data  (dht11_data),
        .busy        (busy),
        .valid       (valid),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .temp_int    (temp_int),
        .temp_dec    (temp_dec),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sensor bits are decoded purely from the high width the sensor model used.
    function automatic logic [39:0] decoded_frame();
        logic [39:0] f;
        for (int i = 0; i < 40; i++) f[39-i] = (hi_w[i] > BIT1_THR_US);
        return f;
    endfunction

    task automatic set_widths(input logic [39:0] f);
        for (int i = 0; i < 40; i++)
            hi_w[i] = f[39-i] ? int'($urandom_range(70, 45)) : int'($urandom_range(38, 15));
    endtask

    task automatic expect_outcome(input int resp_low_us, input bit silent);
        ev_t         e;
        logic [39:0] f;
        logic [7:0]  s;
        f = decoded_frame();
        if (silent || resp_low_us > TIMEOUT_US) begin
            e.kind = K_TMO;
        end else begin
            s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
            e.kind = (s == f[7:0]) ? K_OK : K_CK;
        end
        e.bytes = f[39:8];
        ev_q.push_back(e);
    endtask

    task automatic drive(input bit level, input int us);
        sensor_low = !level;
        repeat (us * DIV) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        chk("busy_before_start", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic sensor(input int resp_low_us, input int abort_bit);
        int n;
        n = 0;
        while (dht11_data !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("start_low_seen", dht11_data, 0);
        n = 0;
        while (dht11_data === 1'b0 && n < START_LOW_US * DIV + 100) begin n++; @(negedge clk); end
        chk("start_low_cycles", n, START_LOW_US * DIV);
        drive(1'b1, 20);
        drive(1'b0, resp_low_us);
        if (resp_low_us > TIMEOUT_US) begin
            sensor_low = 1'b0;
            return;
        end
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 25);
            if (i == abort_bit) begin
                drive(1'b1, 10);
                return;
            end
            drive(1'b1, hi_w[i]);
        end
        drive(1'b0, 25);
        sensor_low = 1'b0;
    endtask

    task automatic wait_events(input int bound, input string name);
        int n;
        n = 0;
        while (ev_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
        chk(name, ev_q.size(), 0);
        ev_q.delete();
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin @(negedge clk); n++; end
        chk("idle_reached", busy, 0);
    endtask

    task automatic run_current(input int resp_low_us);
        expect_outcome(resp_low_us, 1'b0);
        do_start();
        sensor(resp_low_us, -1);
        wait_events(2000, "frame_outcome");
        wait_idle(2000);
    endtask

    task automatic run_frame(input logic [39:0] f, input int resp_low_us);
        set_widths(f);
        run_current(resp_low_us);
    endtask

    // Single compare process: pulses, busy at pulse time and held output bytes.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            model_bytes = '0;
        end else begin
            chk("pulse_exclusive", (int'(valid) + int'(err_checksum) + int'(err_timeout)) <= 1, 1);
            if (valid || err_checksum || err_timeout) begin
                chk("busy_low_at_pulse", busy, 0);
                chk("pulse_expected", ev_q.size() != 0, 1);
                if (ev_q.size() != 0) begin
                    cur_ev   = ev_q.pop_front();
                    got_kind = valid ? K_OK : (err_checksum ? K_CK : K_TMO);
                    chk("pulse_kind", got_kind, cur_ev.kind);
                    if (valid) model_bytes = cur_ev.bytes;
                end
            end
            chk("output_bytes", {hum_int, hum_dec, temp_int, temp_dec}, model_bytes);
        end
    end

    initial begin
        int          n;
        logic [7:0]  rb0, rb1, rb2, rb3, rck;
        logic [39:0] f;

        reset      = 1'b0;
        start      = 1'b0;
        sensor_low = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {valid, err_checksum, err_timeout}, 0);
        chk("reset_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 0);
        chk("reset_bus_released", dht11_data, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_frame({8'd50, 8'd0, 8'd30, 8'd0, 8'd80}, 80);
        chk("t1_hum_int", hum_int, 50);
        chk("t1_hum_dec", hum_dec, 0);
        chk("t1_temp_int", temp_int, 30);
        chk("t1_temp_dec", temp_dec, 0);

        run_frame({8'd50, 8'd0, 8'd30, 8'd0, 8'd81}, 80);
        chk("t2_temp_int_kept", temp_int, 30);

        // Silent sensor: timeout follows the end of the start pulse.
        expect_outcome(0, 1'b1);
        do_start();
        n = 0;
        while (dht11_data === 1'b0 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (!err_timeout && n < 1000) begin @(negedge clk); n++; end
        chk("t3_timeout_latency_ok", (n >= TIMEOUT_US * DIV) && (n <= TIMEOUT_US * DIV + 20), 1);
        chk("t3_bus_released", dht11_data, 1);
        wait_events(100, "t3_outcome");

        run_frame({8'd200, 8'd100, 8'd0, 8'd0, 8'd44}, 80);
        chk("t4_hum_int", hum_int, 200);
        chk("t4_hum_dec", hum_dec, 100);

        // Reset while the host holds the bus low.
        do_start();
        repeat (50) @(negedge clk);
        chk("t5_bus_low_in_start", dht11_data, 0);
        reset = 1'b0;
        #1;
        chk("t5_bus_released_on_reset", dht11_data, 1);
        chk("t5_busy_on_reset", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset during bit 20.
        set_widths({8'd11, 8'd22, 8'd33, 8'd44, 8'd110});
        do_start();
        sensor(80, 20);
        reset = 1'b0;
        #1;
        chk("t5_bus_released_bit20", dht11_data, 1);
        chk("t5_busy_bit20", busy, 0);
        chk("t5_bytes_cleared", {hum_int, hum_dec, temp_int, temp_dec}, 0);
        ev_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_frame({8'd11, 8'd22, 8'd33, 8'd44, 8'd110}, 80);
        chk("t5_clean_hum_int", hum_int, 11);

        // Every bit at the threshold: 40 us decodes 0, 41 us decodes 1.
        f = {8'h55, 8'h0F, 8'h21, 8'h03, 8'h88};
        for (int i = 0; i < 40; i++) hi_w[i] = f[39-i] ? 41 : 40;
        expect_outcome(80, 1'b0);
        do_start();
        fork
            sensor(80, -1);
            begin
                repeat (1000) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_events(2000, "t6_outcome");
        wait_idle(2000);
        chk("t6_hum_int", hum_int, 8'h55);
        chk("t6_temp_dec", temp_dec, 8'h03);
        repeat (900) @(negedge clk);
        chk("t6_start_not_queued", busy, 0);

        // Response-low width right at the limit, then beyond it.
        run_frame({8'd1, 8'd2, 8'd3, 8'd4, 8'd10}, TIMEOUT_US);
        chk("t7_hum_int", hum_int, 1);
        run_frame({8'd9, 8'd9, 8'd9, 8'd9, 8'd36}, TIMEOUT_US + 5);

        for (int r = 0; r < 3; r++) begin
            rb0 = 8'($urandom);
            rb1 = 8'($urandom);
            rb2 = 8'($urandom);
            rb3 = 8'($urandom);
            rck = ($urandom_range(1, 0) == 1) ? 8'(rb0 + rb1 + rb2 + rb3) : 8'($urandom);
            run_frame({rb0, rb1, rb2, rb3, rck}, int'($urandom_range(90, 60)));
        end

        chk("no_pending_events", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
